// File: rtl/dem_giay_phut.sv
// MM:SS BCD counter fed by an edge-detected slow tick, with a validated preset load and a
// multiplexed 4-digit common-anode display. Optional macro: DEM_GIAY_PHUT_BLANK_LEAD_EN.
module dem_giay_phut #(
   parameter int unsigned SCAN_DIV = 50000,
   parameter int unsigned MAX_MIN  = 59
) (
   input  logic        clk_50MHz,
   input  logic        rst_n,
   input  logic        tick_in,
   input  logic        run,
   input  logic        clear,
   input  logic        load_valid,
   input  logic [15:0] load_bcd,
   output logic        load_ack,
   output logic        load_err,
   output logic [15:0] time_bcd,
   output logic        carry_out,
   output logic [3:0]  an_n,
   output logic [6:0]  seg_n,
   output logic        dp_n
);

   localparam int unsigned       SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
   localparam logic [3:0]        MAX_MT    = 4'(MAX_MIN / 10);
   localparam logic [3:0]        MAX_MO    = 4'(MAX_MIN % 10);

   typedef enum logic [1:0] {
      DIG_SEC_ONES = 2'd0,
      DIG_SEC_TENS = 2'd1,
      DIG_MIN_ONES = 2'd2,
      DIG_MIN_TENS = 2'd3
   } digit_e;

   function automatic logic [6:0] seg_decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   logic              tick_dly_q, tick_dly_d;
   logic [15:0]       time_q, time_d;
   logic              ack_q, ack_d;
   logic              err_q, err_d;
   logic              carry_q, carry_d;
   logic [SCAN_W-1:0] scan_q, scan_d;
   digit_e            dig_q, dig_d;
   logic [3:0]        an_q, an_d;
   logic [6:0]        seg_q, seg_d;
   logic              dp_q, dp_d;

   logic              tick_rise;
   logic              load_ok;
   logic [15:0]       inc_time;
   logic              inc_wrap;
   logic [3:0]        digit_val;

   assign tick_rise = tick_in & ~tick_dly_q;

   always_comb begin
      load_ok = (load_bcd[3:0] <= 4'd9) && (load_bcd[7:4] <= 4'd5) &&
                (load_bcd[11:8] <= 4'd9) && (load_bcd[15:12] <= 4'd9) &&
                ((load_bcd[15:12] < MAX_MT) ||
                 ((load_bcd[15:12] == MAX_MT) && (load_bcd[11:8] <= MAX_MO)));
   end

   // Ripple the increment digit by digit; minutes fold to 00 at MAX_MIN rather than 99.
   always_comb begin
      inc_time = time_q;
      inc_wrap = 1'b0;
      if (time_q[3:0] != 4'd9) begin
         inc_time[3:0] = time_q[3:0] + 4'd1;
      end else begin
         inc_time[3:0] = '0;
         if (time_q[7:4] != 4'd5) begin
            inc_time[7:4] = time_q[7:4] + 4'd1;
         end else begin
            inc_time[7:4] = '0;
            if ((time_q[15:12] == MAX_MT) && (time_q[11:8] == MAX_MO)) begin
               inc_time[15:8] = '0;
               inc_wrap       = 1'b1;
            end else if (time_q[11:8] != 4'd9) begin
               inc_time[11:8] = time_q[11:8] + 4'd1;
            end else begin
               inc_time[11:8]  = '0;
               inc_time[15:12] = time_q[15:12] + 4'd1;
            end
         end
      end
   end

   always_comb begin
      tick_dly_d = tick_in;
      time_d     = time_q;
      ack_d      = 1'b0;
      err_d      = 1'b0;
      carry_d    = 1'b0;
      if (clear) begin
         time_d = '0;
      end else if (load_valid) begin
         if (load_ok) begin
            time_d = load_bcd;
            ack_d  = 1'b1;
         end else begin
            err_d = 1'b1;
         end
      end else if (tick_rise && run) begin
         time_d  = inc_time;
         carry_d = inc_wrap;
      end
   end

   always_comb begin
      scan_d = scan_q + SCAN_W'(1);
      dig_d  = dig_q;
      if (scan_q == SCAN_LAST) begin
         scan_d = '0;
         case (dig_q)
            DIG_SEC_ONES: dig_d = DIG_SEC_TENS;
            DIG_SEC_TENS: dig_d = DIG_MIN_ONES;
            DIG_MIN_ONES: dig_d = DIG_MIN_TENS;
            default:      dig_d = DIG_SEC_ONES;
         endcase
      end
   end

   always_comb begin
      digit_val = time_q[3:0];
      an_d      = 4'b1110;
      case (dig_q)
         DIG_SEC_ONES: begin digit_val = time_q[3:0];   an_d = 4'b1110; end
         DIG_SEC_TENS: begin digit_val = time_q[7:4];   an_d = 4'b1101; end
         DIG_MIN_ONES: begin digit_val = time_q[11:8];  an_d = 4'b1011; end
         default:      begin digit_val = time_q[15:12]; an_d = 4'b0111; end
      endcase
      seg_d = seg_decode(digit_val);
      dp_d  = (dig_q != DIG_MIN_ONES);
`ifdef DEM_GIAY_PHUT_BLANK_LEAD_EN
      if ((dig_q == DIG_MIN_TENS) && (time_q[15:12] == 4'd0)) begin
         an_d  = 4'b1111;
         seg_d = 7'b1111111;
      end
`endif
   end

   always_ff @(posedge clk_50MHz or negedge rst_n) begin
      if (!rst_n) begin
         tick_dly_q <= 1'b0;
         time_q     <= '0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         carry_q    <= 1'b0;
         scan_q     <= '0;
         dig_q      <= DIG_SEC_ONES;
         an_q       <= 4'b1110;
         seg_q      <= 7'b1000000;
         dp_q       <= 1'b1;
      end else begin
         tick_dly_q <= tick_dly_d;
         time_q     <= time_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
         carry_q    <= carry_d;
         scan_q     <= scan_d;
         dig_q      <= dig_d;
         an_q       <= an_d;
         seg_q      <= seg_d;
         dp_q       <= dp_d;
      end
   end

   assign time_bcd  = time_q;
   assign load_ack  = ack_q;
   assign load_err  = err_q;
   assign carry_out = carry_q;
   assign an_n      = an_q;
   assign seg_n     = seg_q;
   assign dp_n      = dp_q;

endmodule

// File: tb/tb_dem_giay_phut.sv
// Self-checking bench for dem_giay_phut: directed scenarios plus random traffic against a
// seconds-count model. Honours DEM_GIAY_PHUT_BLANK_LEAD_EN when defined.
module tb_dem_giay_phut;
   localparam int SCAN = 4;
   localparam int MAXM = 59;

   logic        clk_50MHz = 1'b0;
   logic        rst_n, tick_in, run, clear, load_valid;
   logic [15:0] load_bcd;
   logic        load_ack, load_err, carry_out, dp_n;
   logic [15:0] time_bcd;
   logic [3:0]  an_n;
   logic [6:0]  seg_n;

   dem_giay_phut #(.SCAN_DIV(SCAN), .MAX_MIN(MAXM)) dut (
      .clk_50MHz(clk_50MHz), .rst_n(rst_n), .tick_in(tick_in), .run(run), .clear(clear),
      .load_valid(load_valid), .load_bcd(load_bcd), .load_ack(load_ack), .load_err(load_err),
      .time_bcd(time_bcd), .carry_out(carry_out), .an_n(an_n), .seg_n(seg_n), .dp_n(dp_n)
   );

   always #10 clk_50MHz = ~clk_50MHz;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] seg_of(input int v);
      case (v)
         0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
         3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
         6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [15:0] bcd_of(input int s);
      int m, x;
      m = s / 60;
      x = s % 60;
      return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
   endfunction

   // Reference model: time kept as total seconds, display slot derived from elapsed cycles.
   int         m_secs, m_scan, m_wraps = 0;
   bit         m_prev, m_ack, m_err, m_carry;
   logic [3:0] m_an;
   logic [6:0] m_seg;
   logic       m_dp;
   int         md_dig, md_val, ld_mt, ld_mo, ld_st, ld_so;
   logic [15:0] md_b;
   bit         md_rise;

   always @(posedge clk_50MHz or negedge rst_n) begin
      if (!rst_n) begin
         m_secs = 0; m_scan = 0; m_prev = 0;
         m_ack = 0; m_err = 0; m_carry = 0;
         m_an = 4'b1110; m_seg = 7'b1000000; m_dp = 1'b1;
      end else begin
         md_dig = (m_scan / SCAN) % 4;
         md_b   = bcd_of(m_secs);
         md_val = int'(md_b[md_dig*4 +: 4]);
         m_an   = ~(4'b0001 << md_dig);
         m_seg  = seg_of(md_val);
         m_dp   = (md_dig != 2);
`ifdef DEM_GIAY_PHUT_BLANK_LEAD_EN
         if (md_dig == 3 && md_b[15:12] == 4'd0) begin
            m_an  = 4'b1111;
            m_seg = 7'b1111111;
         end
`endif
         md_rise = tick_in && !m_prev;
         m_prev  = tick_in;
         m_ack = 0; m_err = 0; m_carry = 0;
         if (clear) begin
            m_secs = 0;
         end else if (load_valid) begin
            ld_mt = int'(load_bcd[15:12]); ld_mo = int'(load_bcd[11:8]);
            ld_st = int'(load_bcd[7:4]);   ld_so = int'(load_bcd[3:0]);
            if (ld_mt <= 9 && ld_mo <= 9 && ld_st <= 5 && ld_so <= 9 && ld_mt*10 + ld_mo <= MAXM) begin
               m_secs = (ld_mt*10 + ld_mo)*60 + ld_st*10 + ld_so;
               m_ack  = 1;
            end else begin
               m_err = 1;
            end
         end else if (md_rise && run) begin
            m_secs = m_secs + 1;
            if (m_secs == (MAXM + 1) * 60) begin
               m_secs  = 0;
               m_carry = 1;
               m_wraps++;
            end
         end
         m_scan++;
      end
   end

   always @(negedge clk_50MHz) begin
      if (rst_n === 1'b1) begin
         chk("time_bcd", 32'(time_bcd), 32'(bcd_of(m_secs)));
         chk("load_ack", 32'(load_ack), 32'(m_ack));
         chk("load_err", 32'(load_err), 32'(m_err));
         chk("carry_out", 32'(carry_out), 32'(m_carry));
         chk("an_n", 32'(an_n), 32'(m_an));
         chk("seg_n", 32'(seg_n), 32'(m_seg));
         chk("dp_n", 32'(dp_n), 32'(m_dp));
         chk("ack_err_excl", 32'(load_ack & load_err), 32'(0));
      end
   end

   int carry_seen = 0;
   always @(negedge clk_50MHz) if (carry_out === 1'b1) carry_seen++;

   task automatic cyc(input int n);
      repeat (n) @(negedge clk_50MHz);
   endtask

   task automatic do_tick();
      tick_in = 1'b1; cyc(1);
      tick_in = 1'b0; cyc(1);
   endtask

   task automatic do_load(input logic [15:0] v);
      load_valid = 1'b1; load_bcd = v; cyc(1);
      load_valid = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_time"}, 32'(time_bcd), 32'h0);
      chk({tag, "_an"}, 32'(an_n), 32'(4'b1110));
      chk({tag, "_seg"}, 32'(seg_n), 32'(7'b1000000));
      chk({tag, "_dp"}, 32'(dp_n), 32'(1));
      chk({tag, "_pulses"}, 32'({load_ack, load_err, carry_out}), 32'(0));
   endtask

   int n_slot [4];
   int n_blank;
   logic [15:0] rv;

   initial begin
      rst_n = 1'b0; tick_in = 1'b0; run = 1'b0; clear = 1'b0;
      load_valid = 1'b0; load_bcd = '0;
      #35;
      chk_reset_outputs("reset");
      @(negedge clk_50MHz); rst_n = 1'b1;

      // 1: ten ticks
      run = 1'b1;
      repeat (10) do_tick();
      chk("t1_time", 32'(time_bcd), 32'h0010);
      chk("t1_no_carry", 32'(carry_seen), 32'(0));

      // 2: preset to maximum, then wrap
      do_load(16'h5959);
      chk("t2_ack", 32'(load_ack), 32'(1));
      chk("t2_time", 32'(time_bcd), 32'h5959);
      cyc(1);
      chk("t2_ack_gone", 32'(load_ack), 32'(0));
      tick_in = 1'b1; cyc(1);
      chk("t2_wrap_time", 32'(time_bcd), 32'h0000);
      chk("t2_carry", 32'(carry_out), 32'(1));
      tick_in = 1'b0; cyc(1);
      chk("t2_carry_gone", 32'(carry_out), 32'(0));

      // 3: rejected presets
      do_load(16'h0570);
      chk("t3_err", 32'({load_err, load_ack}), 32'(2'b10));
      chk("t3_time", 32'(time_bcd), 32'h0000);
      do_load(16'h6000);
      chk("t3b_err", 32'({load_err, load_ack}), 32'(2'b10));
      chk("t3b_time", 32'(time_bcd), 32'h0000);

      // 4: clear beats load and tick
      do_load(16'h1234);
      chk("t4_pre", 32'(time_bcd), 32'h1234);
      clear = 1'b1; load_valid = 1'b1; load_bcd = 16'h0001; tick_in = 1'b1;
      cyc(1);
      clear = 1'b0; load_valid = 1'b0; tick_in = 1'b0;
      chk("t4_time", 32'(time_bcd), 32'h0000);
      chk("t4_pulses", 32'({load_ack, load_err}), 32'(0));
      cyc(1);

      // 5: ticks dropped while stopped
      run = 1'b0;
      repeat (3) do_tick();
      run = 1'b1;
      do_tick();
      chk("t5_time", 32'(time_bcd), 32'h0001);

      // 6: display scan of 07:12
      run = 1'b0;
      do_load(16'h0712);
      cyc(2);
      for (int i = 0; i < 4; i++) n_slot[i] = 0;
      n_blank = 0;
      for (int c = 0; c < 20; c++) begin
         case (an_n)
            4'b1110: begin chk("t6_seg0", 32'(seg_n), 32'(7'b0100100)); chk("t6_dp0", 32'(dp_n), 32'(1)); n_slot[0]++; end
            4'b1101: begin chk("t6_seg1", 32'(seg_n), 32'(7'b1111001)); chk("t6_dp1", 32'(dp_n), 32'(1)); n_slot[1]++; end
            4'b1011: begin chk("t6_seg2", 32'(seg_n), 32'(7'b1111000)); chk("t6_dp2", 32'(dp_n), 32'(0)); n_slot[2]++; end
            4'b0111: begin chk("t6_seg3", 32'(seg_n), 32'(7'b1000000)); chk("t6_dp3", 32'(dp_n), 32'(1)); n_slot[3]++; end
            4'b1111: begin chk("t6_blank_seg", 32'(seg_n), 32'(7'b1111111)); n_blank++; end
            default: chk("t6_an_legal", 32'(an_n), 32'(4'b1110));
         endcase
         cyc(1);
      end
`ifdef DEM_GIAY_PHUT_BLANK_LEAD_EN
      chk("t6_slots", 32'({n_slot[0] > 0, n_slot[1] > 0, n_slot[2] > 0, n_slot[3] > 0, n_blank > 0}), 32'(5'b11101));
`else
      chk("t6_slots", 32'({n_slot[0] > 0, n_slot[1] > 0, n_slot[2] > 0, n_slot[3] > 0, n_blank > 0}), 32'(5'b11110));
`endif

      // 7: random traffic
      for (int c = 0; c < 3000; c++) begin
         tick_in    = 1'($urandom_range(0, 1));
         run        = ($urandom_range(0, 9) != 0);
         clear      = ($urandom_range(0, 149) == 0);
         load_valid = ($urandom_range(0, 24) == 0);
         case ($urandom_range(0, 3))
            0: rv = 16'($urandom);
            1: rv = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
            2: rv = ($urandom_range(0, 1) == 0) ? 16'h5959 : 16'h5958;
            default: rv = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 6)), 4'($urandom_range(0, 9))};
         endcase
         load_bcd = rv;
         cyc(1);
      end
      clear = 1'b0; load_valid = 1'b0; tick_in = 1'b0;
      chk("rand_wraps_seen", 32'(m_wraps > 1), 32'(1));

      // 8: asynchronous reset mid-run, with tick_in high at release
      do_load(16'h4321);
      @(posedge clk_50MHz); #3;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("midreset");
      tick_in = 1'b1; run = 1'b1;
      cyc(2);
      rst_n = 1'b1;
      cyc(1);
      chk("release_tick_time", 32'(time_bcd), 32'h0001);
      tick_in = 1'b0;
      cyc(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL timeout: bench did not finish, got running expected done");
      $fatal(1, "timeout");
   end
endmodule
